// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - EX-stage PC register, control-flow redirect, squash and misaligned-target trap
module pc_redirect_unit #(
  parameter int unsigned        LENGTH       = 32,
  parameter logic [LENGTH-1:0]  RESET_VECTOR = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic              branch,
  input  logic              branch_taken,
  input  logic [LENGTH-1:0] branch_target,
  input  logic              jal,
  input  logic [LENGTH-1:0] jal_target,
  input  logic              jalr,
  input  logic [LENGTH-1:0] jalr_target,
  output logic [LENGTH-1:0] pc,
  output logic [LENGTH-1:0] pc_plus4,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              trap,
  output logic [LENGTH-1:0] trap_addr,
  output logic [31:0]       redirect_count
);

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [LENGTH-1:0] pc_q, pc_d;
  logic [LENGTH-1:0] trap_addr_q, trap_addr_d;
  logic [31:0]       redirect_count_q, redirect_count_d;

  logic [LENGTH-1:0] target;
  logic              req;
  logic              aligned;
  logic              flush;

  // Select the effective target (jalr > jal > branch) and decode a redirect request
  always_comb begin
    target = branch_target;
    if (jalr) begin
      target = {jalr_target[LENGTH-1:1], 1'b0};
    end else if (jal) begin
      target = jal_target;
    end
    req     = ex_valid & (jal | jalr | (branch & branch_taken));
    aligned = (target[1:0] == 2'b00);
  end

  // Next-state logic: redirect, trap entry, sequential fetch or hold
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    trap_addr_d      = trap_addr_q;
    redirect_count_d = redirect_count_q;
    flush            = 1'b0;
    unique case (state_q)
      RUN: begin
        if (req) begin
          // Both younger instructions are wrong-path whether or not the target is legal
          flush = 1'b1;
          if (aligned) begin
            pc_d             = target;
            redirect_count_d = redirect_count_q + 32'd1;
          end else begin
            state_d     = TRAP;
            trap_addr_d = target;
          end
        end else if (!stall) begin
          pc_d = pc_q + LENGTH'(4);
        end
      end
      TRAP: begin
        // Keep squashing so the pipeline drains to bubbles until reset
        flush = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State registers; reset overrides any redirect or trap in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= RUN;
      pc_q             <= RESET_VECTOR;
      trap_addr_q      <= '0;
      redirect_count_q <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      trap_addr_q      <= trap_addr_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign pc             = pc_q;
  assign pc_plus4       = pc_q + LENGTH'(4);
  assign flush_if_id    = flush & ~reset;
  assign flush_id_ex    = flush & ~reset;
  assign trap           = (state_q == TRAP);
  assign trap_addr      = trap_addr_q;
  assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - scoreboard bench for pc_redirect_unit
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        reset, stall, ex_valid, branch, branch_taken, jal, jalr;
  logic [31:0] branch_target, jal_target, jalr_target;
  logic [31:0] pc, pc_plus4, trap_addr, redirect_count;
  logic        flush_if_id, flush_id_ex, trap;

  pc_redirect_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
    .branch(branch), .branch_taken(branch_taken), .branch_target(branch_target),
    .jal(jal), .jal_target(jal_target), .jalr(jalr), .jalr_target(jalr_target),
    .pc(pc), .pc_plus4(pc_plus4), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .trap(trap), .trap_addr(trap_addr), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        trap;
    logic [31:0] taddr;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] m_pc, m_taddr, m_cnt;
  logic        m_trap;

  // Count one comparison and report it when observed and expected differ
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Clear all inputs except reset
  task automatic idle_inputs();
    stall = 0; ex_valid = 0; branch = 0; branch_taken = 0; jal = 0; jalr = 0;
    branch_target = '0; jal_target = '0; jalr_target = '0;
  endtask

  // One clock: check flushes, push the model's next state, then pop after the edge
  task automatic cycle(input string tag);
    logic [31:0] t;
    logic        rq, fl;
    exp_t        e, o;
    #1;
    t  = jalr ? {jalr_target[31:1], 1'b0} : (jal ? jal_target : branch_target);
    rq = ex_valid & (jal | jalr | (branch & branch_taken));
    fl = !reset && (m_trap || rq);
    chk({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, fl});
    chk({tag, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, fl});
    e.pc = m_pc; e.trap = m_trap; e.taddr = m_taddr; e.cnt = m_cnt;
    if (reset) begin
      e.pc = 32'h0040_0000; e.trap = 0; e.taddr = 0; e.cnt = 0;
    end else if (!m_trap) begin
      if (rq) begin
        if (t[1:0] == 2'b00) begin
          e.pc = t; e.cnt = m_cnt + 1;
        end else begin
          e.trap = 1; e.taddr = t;
        end
      end else if (!stall) begin
        e.pc = m_pc + 4;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      o = sb_q.pop_front();
      chk({tag, ".pc"},        pc,       o.pc);
      chk({tag, ".pc_plus4"},  pc_plus4, o.pc + 4);
      chk({tag, ".trap"},      {31'd0, trap}, {31'd0, o.trap});
      chk({tag, ".trap_addr"}, trap_addr, o.taddr);
      chk({tag, ".count"},     redirect_count, o.cnt);
      m_pc = o.pc; m_trap = o.trap; m_taddr = o.taddr; m_cnt = o.cnt;
    end
  endtask

  initial begin
    m_pc = 32'hDEAD_BEEF; m_trap = 0; m_taddr = 0; m_cnt = 0;
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    cycle("reset");
    chk("reset.pc_const", pc, 32'h0040_0000);
    reset = 0;

    // Sequential fetch
    cycle("seq0"); cycle("seq1");
    chk("seq.pc_const", pc, 32'h0040_0008);

    // Load-use stall holds the PC
    stall = 1;
    cycle("stall0"); cycle("stall1");
    chk("stall.pc_const", pc, 32'h0040_0008);
    stall = 0;
    cycle("resume");
    chk("resume.pc_const", pc, 32'h0040_000C);

    // Taken branch overrides stall
    stall = 1; ex_valid = 1; branch = 1; branch_taken = 1; branch_target = 32'h0040_0040;
    cycle("beq_taken");
    chk("beq.pc_const", pc, 32'h0040_0040);
    chk("beq.count_const", redirect_count, 32'd1);
    branch_taken = 0; stall = 0;
    cycle("beq_not_taken");
    chk("beq_nt.pc_const", pc, 32'h0040_0044);
    idle_inputs();

    // JALR clears bit 0
    ex_valid = 1; jalr = 1; jalr_target = 32'h0040_0101;
    cycle("jalr");
    chk("jalr.pc_const", pc, 32'h0040_0100);
    idle_inputs();

    // JAL from a bubble is ignored
    jal = 1; jal_target = 32'h0040_0020;
    cycle("jal_bubble");
    chk("jal_bubble.pc_const", pc, 32'h0040_0104);
    idle_inputs();

    // Priority: jalr wins over jal and branch
    ex_valid = 1; jalr = 1; jal = 1; branch = 1; branch_taken = 1;
    jalr_target = 32'h0040_0200; jal_target = 32'h0040_0300; branch_target = 32'h0040_0400;
    cycle("prio_jalr");
    jalr = 0;
    cycle("prio_jal");
    idle_inputs();

    // Random aligned traffic (jalr targets keep bit 1 clear)
    for (int i = 0; i < 12; i++) begin
      stall = 1'($urandom); ex_valid = 1'($urandom);
      branch = 0; jal = 0; jalr = 0;
      case ($urandom_range(0, 3))
        0: branch = 1;
        1: jal = 1;
        2: jalr = 1;
        default: ;
      endcase
      branch_taken  = 1'($urandom);
      branch_target = $urandom & 32'hFFFF_FFFC;
      jal_target    = $urandom & 32'hFFFF_FFFC;
      jalr_target   = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      cycle($sformatf("rand%0d", i));
    end
    idle_inputs();

    // PC wrap on sequential increment
    ex_valid = 1; jal = 1; jal_target = 32'hFFFF_FFFC;
    cycle("jal_top");
    idle_inputs();
    cycle("pc_wrap");
    chk("pc_wrap.pc_const", pc, 32'h0000_0000);

    // Counter wrap via preload of the next-count value
    stall = 1;
    force dut.redirect_count_d = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.redirect_count_d;
    m_cnt = 32'hFFFF_FFFF;
    chk("preload.count", redirect_count, 32'hFFFF_FFFF);
    stall = 0; ex_valid = 1; jal = 1; jal_target = 32'h0040_0000;
    cycle("count_wrap");
    chk("count_wrap.count_const", redirect_count, 32'd0);
    idle_inputs();

    // Misaligned JAL enters TRAP
    ex_valid = 1; jal = 1; jal_target = 32'h0040_0022;
    cycle("trap_entry");
    chk("trap.addr_const", trap_addr, 32'h0040_0022);
    chk("trap.flag_const", {31'd0, trap}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      stall = 1'($urandom); ex_valid = 1'($urandom); branch = 1'($urandom);
      branch_taken = 1'($urandom); jal = 1'($urandom); jalr = 1'($urandom);
      branch_target = $urandom; jal_target = $urandom; jalr_target = $urandom;
      cycle($sformatf("trap_hold%0d", i));
    end

    // Reset out of TRAP with a request still presented
    ex_valid = 1; jal = 1; jal_target = 32'h0040_0080;
    reset = 1;
    cycle("trap_reset");
    chk("trap_reset.pc_const", pc, 32'h0040_0000);
    chk("trap_reset.trap_const", {31'd0, trap}, 32'd0);
    reset = 0;
    idle_inputs();
    cycle("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Fetch-side program-counter and control-flow redirect unit for the RISC-V core. It sits directly downstream of the ALU, in the EX stage. It consumes the ALU's `branch` / `branch_taken` outputs together with the jump targets, and owns the PC register. It also produces the squash signals for the IF/ID and ID/EX pipeline registers, traps misaligned control-flow targets, and keeps a count of taken redirects.

## Interface
Parameters:
- `LENGTH`, 32, datapath and PC width.
- `RESET_VECTOR`, 32'h0040_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard-unit hold request for IF/ID (load-use).
- `ex_valid`  in  1  the EX-stage instruction is real, not a bubble.
- `branch`  in  1  ALU `branch` output (a conditional branch is in EX).
- `branch_taken`  in  1  ALU branch condition result.
- `branch_target`  in  LENGTH  EX-stage PC + B-immediate.
- `jal`  in  1  JAL is in EX.
- `jal_target`  in  LENGTH  EX-stage PC + J-immediate.
- `jalr`  in  1  JALR is in EX.
- `jalr_target`  in  LENGTH  ALU `result` (rs1 + I-immediate).
- `pc`  out  LENGTH  current fetch address.
- `pc_plus4`  out  LENGTH  `pc + 4`, combinational.
- `flush_if_id`  out  1  squash the IF/ID register at this edge.
- `flush_id_ex`  out  1  squash the ID/EX register at this edge.
- `trap`  out  1  sticky misaligned-target trap.
- `trap_addr`  out  LENGTH  offending target, latched at trap entry.
- `redirect_count`  out  32  number of accepted redirects; wraps.

## Operation
- States: RUN and TRAP. Reset enters RUN.
- Effective target:
  - JAL uses `jal_target`.
  - JALR uses `{jalr_target[LENGTH-1:1],1'b0}`, per the ISA, which clears bit 0.
  - A taken branch uses `branch_target`.
- Request: `req = ex_valid & (jal | jalr | (branch & branch_taken))`.
  - At most one of `jal`, `jalr`, `branch` is high. If more than one is high, the priority is jalr, then jal, then branch.
  - A not-taken branch (`branch=1`, `branch_taken=0`) is not a request.
- In RUN with `req` and target[1:0]==0 (accepted redirect):
  - At the next edge, `pc` <= target and `redirect_count` increments.
  - `flush_if_id` and `flush_id_ex` are 1 in the same cycle, combinational from `req`.
  - A redirect overrides `stall`.
- In RUN with `req` and target[1:0]!=0 (misaligned):
  - At the next edge, go to TRAP, `trap_addr` <= target, and `pc` holds.
  - Both flushes are 1 in that cycle.
  - `redirect_count` does not increment.
- In RUN with no `req`:
  - If `stall`=1, `pc` holds.
  - Otherwise `pc` <= `pc + 4`, with modulo-2^LENGTH wrap.
  - Both flushes are 0.
- In TRAP:
  - `pc` holds and `trap`=1.
  - Both flushes are held at 1, so the pipeline drains to bubbles.
  - All inputs except `reset` are ignored.
  - The only exit is `reset`.
- `reset`=1 takes precedence over everything at the edge.

## Timing
- Reset values: `pc`=RESET_VECTOR, `trap`=0, `trap_addr`=0, `redirect_count`=0, state RUN.
- During the reset cycle the flush outputs are 0. The `flush_*` outputs are combinational and depend on state and `req`.
- Redirect latency: a request presented in cycle N produces `pc`=target in cycle N+1.
  - Exactly the two younger instructions are squashed, both at the edge ending cycle N: the one in IF/ID and the one in ID/EX.
- Cycle N+1 contains a bubble in EX (`ex_valid`=0), so no back-to-back redirect is possible from squashed work.
- `pc_plus4` follows `pc` in the same cycle.
- `redirect_count` wraps from 0xFFFF_FFFF to 0.
- `pc` wraps from 0xFFFF_FFFC to 0 on a sequential increment.
- A reset asserted mid-redirect or in TRAP restores every reset value at that edge. There is no flush in the reset cycle.

## Test plan
- Reset release, no requests, `stall`=0 for 4 cycles -> `pc` reads 0x00400000, 0x00400004, 0x00400008, 0x0040000C; flushes stay 0.
- `stall`=1 for 2 cycles at `pc`=0x00400008 -> `pc` holds at 0x00400008 for both cycles, then resumes at 0x0040000C.
- BEQ taken: `ex_valid`=1, `branch`=1, `branch_taken`=1, `branch_target`=0x00400040, with `stall`=1 -> both flushes are 1 that cycle; next `pc`=0x00400040; `redirect_count`=1. The same stimulus with `branch_taken`=0 -> no flush and `pc`+4.
- JALR with `jalr_target`=0x00400101 -> effective target 0x00400100 and a redirect. JAL with `jal_target`=0x00400020 and `ex_valid`=0 -> ignored.
- JAL with `jal_target`=0x00400022 -> `trap`=1 and `trap_addr`=0x00400022; `pc` frozen; flushes held at 1 over 5 cycles with random inputs; `redirect_count` unchanged. Then `reset` -> all outputs return to their reset values.
- Set `redirect_count` to 0xFFFF_FFFF with a forced preload, then make one accepted redirect -> `redirect_count`=0.
